clint_rtc: RTL and testbench

//  Core-local interruptor (CLINT) for the wolv-z1 SoC bus, decoded at clint_base_addr..clint_top_addr.

---
 rtl/clint_rtc.sv | 122 ++++++++++++
 tb/tb_clint_rtc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_rtc.sv
// Core-local interruptor: msip, 64-bit mtimecmp and an RTC-driven 64-bit mtime on a one-cycle-latency bus.
// Optional macro CLINT_MTIME_WRITE_EN makes mtime writable; without it mtime only resets and ticks.
module clint_rtc #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
    parameter int          RTC_DIV    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [3:0]  clint_wstrb,
    input  logic [31:0] clint_wdata,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam logic [7:0]  RTC_TERM       = 8'(2 * RTC_DIV + 1);
    localparam logic [31:0] OFF_MSIP       = 32'h0000_0000;
    localparam logic [31:0] OFF_MTIMECMP_L = 32'h0000_4000;
    localparam logic [31:0] OFF_MTIMECMP_H = 32'h0000_4004;
    localparam logic [31:0] OFF_MTIME_L    = 32'h0000_BFF8;
    localparam logic [31:0] OFF_MTIME_H    = 32'h0000_BFFC;

    logic [7:0]  r_rtcCnt;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_mtip;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic        w_tick;
    logic        w_inRange;
    logic        w_wr;
    logic [31:0] w_offset;
    logic [31:0] w_rdMux;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
        end
        return res;
    endfunction

    assign w_tick    = (r_rtcCnt == RTC_TERM);
    assign w_offset  = clint_addr - CLINT_BASE;
    assign w_inRange = (clint_addr >= CLINT_BASE) && (clint_addr < CLINT_TOP);
    assign w_wr      = clint_valid && w_inRange && (clint_wstrb != 4'h0);

    // Read data is taken from pre-write state so a write returns the old contents.
    always_comb begin
        w_rdMux = 32'h0;
        if (w_inRange) begin
            case (w_offset)
                OFF_MSIP:       w_rdMux = {31'h0, r_msip};
                OFF_MTIMECMP_L: w_rdMux = r_mtimecmp[31:0];
                OFF_MTIMECMP_H: w_rdMux = r_mtimecmp[63:32];
                OFF_MTIME_L:    w_rdMux = r_mtime[31:0];
                OFF_MTIME_H:    w_rdMux = r_mtime[63:32];
                default:        w_rdMux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rtcCnt   <= 8'h0;
            r_mtime    <= 64'h0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_rtcCnt <= w_tick ? 8'h0 : r_rtcCnt + 8'h1;
            r_ready  <= clint_valid;
            r_mtip   <= (r_mtime >= r_mtimecmp);
            if (clint_valid) begin
                r_rdata <= w_rdMux;
            end

            if (w_wr && (w_offset == OFF_MSIP) && clint_wstrb[0]) begin
                r_msip <= clint_wdata[0];
            end
            if (w_wr && (w_offset == OFF_MTIMECMP_L)) begin
                r_mtimecmp[31:0] <= mergeBytes(r_mtimecmp[31:0], clint_wdata, clint_wstrb);
            end
            if (w_wr && (w_offset == OFF_MTIMECMP_H)) begin
                r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], clint_wdata, clint_wstrb);
            end

`ifdef CLINT_MTIME_WRITE_EN
            // A software write to mtime overrides a coincident tick; that increment is dropped.
            if (w_wr && (w_offset == OFF_MTIME_L)) begin
                r_mtime[31:0] <= mergeBytes(r_mtime[31:0], clint_wdata, clint_wstrb);
            end else if (w_wr && (w_offset == OFF_MTIME_H)) begin
                r_mtime[63:32] <= mergeBytes(r_mtime[63:32], clint_wdata, clint_wstrb);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'h1;
            end
`else
            if (w_tick) begin
                r_mtime <= r_mtime + 64'h1;
            end
`endif
        end
    end

    assign clint_rdata = r_rdata;
    assign clint_ready = r_ready;
    assign clint_msip  = r_msip;
    assign clint_mtip  = r_mtip;
    assign clint_mtime = r_mtime;

endmodule

// File: tb/tb_clint_rtc.sv
// Directed self-checking bench for clint_rtc (RTC_DIV=4, tick every 10 clocks).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clint_rtc;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clint_valid = 1'b0;
    logic [31:0] clint_addr = 32'h0;
    logic [3:0]  clint_wstrb = 4'h0;
    logic [31:0] clint_wdata = 32'h0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    int checkCount = 0;
    int errorCount = 0;
    longint unsigned edgeCnt = 0;
    logic [63:0] expTime;
    logic [63:0] prevTime;
    logic        synced;

    clint_rtc #(.CLINT_BASE(BASE), .CLINT_TOP(32'h0200_C000), .RTC_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_addr  (clint_addr),
        .clint_wstrb (clint_wstrb),
        .clint_wdata (clint_wdata),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    always #5 clock = ~clock;

    // Clocks since reset release; mtime must equal edgeCnt/10 while nothing writes it.
    always @(posedge clock) begin
        if (!reset) edgeCnt <= edgeCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One request issued at a falling edge; returns at the next falling edge with the response visible.
    task automatic applyStimulus(input logic [15:0] offset, input logic [3:0] wstrb, input logic [31:0] wdata);
        clint_valid = 1'b1;
        clint_addr  = BASE + {16'h0, offset};
        clint_wstrb = wstrb;
        clint_wdata = wdata;
        @(negedge clock);
        clint_valid = 1'b0;
        clint_wstrb = 4'h0;
        clint_wdata = 32'h0;
    endtask

    task automatic readCheck(input string tag, input logic [15:0] offset, input logic [31:0] expected);
        applyStimulus(offset, 4'h0, 32'h0);
        checkOutput({tag, "_ready"}, {63'h0, clint_ready}, 64'h1);
        checkOutput(tag, {32'h0, clint_rdata}, {32'h0, expected});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_ready", {63'h0, clint_ready}, 64'h0);
        checkOutput("rst_rdata", {32'h0, clint_rdata}, 64'h0);
        checkOutput("rst_mtip", {63'h0, clint_mtip}, 64'h0);
        checkOutput("rst_msip", {63'h0, clint_msip}, 64'h0);
        checkOutput("rst_mtime", clint_mtime, 64'h0);
        reset = 1'b0;

        // Free-running RTC: 100 clocks -> mtime 10, then exactly 10 more clocks per tick.
        repeat (100) @(negedge clock);
        checkOutput("idle100_mtime", clint_mtime, 64'd10);
        checkOutput("idle100_mtip", {63'h0, clint_mtip}, 64'h0);
        checkOutput("idle100_msip", {63'h0, clint_msip}, 64'h0);
        repeat (9) @(negedge clock);
        checkOutput("tick_not_yet", clint_mtime, 64'd10);
        @(negedge clock);
        checkOutput("tick_period", clint_mtime, 64'd11);

        // Timer compare at 20.
        applyStimulus(16'h4004, 4'hF, 32'h0);
        applyStimulus(16'h4000, 4'hF, 32'd20);
        readCheck("cmp_lo_rd", 16'h4000, 32'd20);
        readCheck("cmp_hi_rd", 16'h4004, 32'h0);
        for (int i = 0; i < 200 && clint_mtime != 64'd20; i++) @(negedge clock);
        checkOutput("mtime_reach20", clint_mtime, 64'd20);
        checkOutput("mtip_lag", {63'h0, clint_mtip}, 64'h0);
        @(negedge clock);
        checkOutput("mtip_rise", {63'h0, clint_mtip}, 64'h1);
        applyStimulus(16'h4000, 4'hF, 32'hFFFF_FFFF);
        checkOutput("mtip_hold_edge", {63'h0, clint_mtip}, 64'h1);
        applyStimulus(16'h4004, 4'hF, 32'hFFFF_FFFF);
        checkOutput("mtip_fall", {63'h0, clint_mtip}, 64'h0);
        applyStimulus(16'h4000, 4'b0001, 32'h0000_0000);
        readCheck("cmp_byte_lane", 16'h4000, 32'hFFFF_FF00);

        // Software interrupt register.
        applyStimulus(16'h0000, 4'hF, 32'h1);
        checkOutput("msip_wr_ready", {63'h0, clint_ready}, 64'h1);
        checkOutput("msip_set", {63'h0, clint_msip}, 64'h1);
        @(negedge clock);
        checkOutput("ready_single", {63'h0, clint_ready}, 64'h0);
        readCheck("msip_rd", 16'h0000, 32'h1);
        applyStimulus(16'h0000, 4'hE, 32'h0);
        checkOutput("msip_no_lane0", {63'h0, clint_msip}, 64'h1);
        applyStimulus(16'h0000, 4'hF, 32'hFFFF_FFFE);
        checkOutput("msip_clr_bit0", {63'h0, clint_msip}, 64'h0);
        applyStimulus(16'h0000, 4'hF, 32'hFFFF_FFFF);
        readCheck("msip_upper_zero", 16'h0000, 32'h1);
        applyStimulus(16'h0000, 4'hF, 32'h0);
        checkOutput("msip_clear", {63'h0, clint_msip}, 64'h0);

`ifdef CLINT_MTIME_WRITE_EN
        // Carry from lo into hi after a software write.
        applyStimulus(16'hBFFC, 4'hF, 32'h0);
        applyStimulus(16'hBFF8, 4'hF, 32'hFFFF_FFFF);
        checkOutput("mtime_wr", clint_mtime, 64'h0000_0000_FFFF_FFFF);
        for (int i = 0; i < 12 && clint_mtime == 64'h0000_0000_FFFF_FFFF; i++) @(negedge clock);
        checkOutput("mtime_carry", clint_mtime, 64'h0000_0001_0000_0000);
        readCheck("mtime_hi_rd", 16'hBFFC, 32'h1);
        applyStimulus(16'hBFFC, 4'hF, 32'h0);
`else
        applyStimulus(16'hBFF8, 4'hF, 32'hFFFF_FFFF);
        checkOutput("mtime_ro_ready", {63'h0, clint_ready}, 64'h1);
        checkOutput("mtime_ro_lo", clint_mtime, edgeCnt / 10);
        applyStimulus(16'hBFFC, 4'hF, 32'h5);
        checkOutput("mtime_ro_hi", clint_mtime, edgeCnt / 10);
`endif

        // Align to a tick, then issue a write to mtime lo on the next tick edge.
        synced = 1'b0;
        for (int i = 0; i < 20 && !synced; i++) begin
            prevTime = clint_mtime;
            @(negedge clock);
            if (clint_mtime != prevTime) synced = 1'b1;
        end
        checkOutput("tick_sync", {63'h0, synced}, 64'h1);
        repeat (9) @(negedge clock);
        applyStimulus(16'hBFF8, 4'hF, 32'h100);
`ifdef CLINT_MTIME_WRITE_EN
        expTime = 64'h100;
`else
        expTime = edgeCnt / 10;
`endif
        checkOutput("tick_collision", clint_mtime, expTime);

        // Back-to-back reads of mtime lo then hi.
        clint_valid = 1'b1;
        clint_addr  = BASE + 32'hBFF8;
        clint_wstrb = 4'h0;
        @(negedge clock);
        checkOutput("b2b_ready1", {63'h0, clint_ready}, 64'h1);
        checkOutput("b2b_lo", {32'h0, clint_rdata}, {32'h0, expTime[31:0]});
        clint_addr = BASE + 32'hBFFC;
        @(negedge clock);
        checkOutput("b2b_ready2", {63'h0, clint_ready}, 64'h1);
        checkOutput("b2b_hi", {32'h0, clint_rdata}, {32'h0, expTime[63:32]});
        clint_valid = 1'b0;
        @(negedge clock);
        checkOutput("b2b_ready_end", {63'h0, clint_ready}, 64'h0);

        // Unmapped offset.
        readCheck("unmapped_rd", 16'h0100, 32'h0);
        applyStimulus(16'h0100, 4'hF, 32'hFFFF_FFFF);
        checkOutput("unmapped_wr_msip", {63'h0, clint_msip}, 64'h0);

        // Load non-reset state, then reset during a request.
        applyStimulus(16'h0000, 4'hF, 32'h1);
        readCheck("pre_rst_msip", 16'h0000, 32'h1);
        applyStimulus(16'h4004, 4'hF, 32'h0);
        applyStimulus(16'h4000, 4'hF, 32'h0);
        @(negedge clock);
        checkOutput("pre_rst_mtip", {63'h0, clint_mtip}, 64'h1);
        clint_valid = 1'b1;
        clint_addr  = BASE;
        reset       = 1'b1;
        @(negedge clock);
        clint_valid = 1'b0;
        checkOutput("rst_req_ready", {63'h0, clint_ready}, 64'h0);
        checkOutput("rst_req_rdata", {32'h0, clint_rdata}, 64'h0);
        checkOutput("rst_req_msip", {63'h0, clint_msip}, 64'h0);
        checkOutput("rst_req_mtip", {63'h0, clint_mtip}, 64'h0);
        checkOutput("rst_req_mtime", clint_mtime, 64'h0);
        @(negedge clock);
        checkOutput("rst_hold_ready", {63'h0, clint_ready}, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("post_rst_mtip", {63'h0, clint_mtip}, 64'h0);
        checkOutput("post_rst_mtime", clint_mtime, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
